// File: rtl/sqrt_sched_pkg.sv
// Shared types and width helpers for the sqrt scheduler.
package sqrt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Result width of an integer square root of a din_w-bit radicand.
  function automatic int calc_dout_w(input int din_w);
    return din_w / 2 + din_w % 2;
  endfunction

  // Requester index width; never narrower than one bit.
  function automatic int calc_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sqrt.sv
// Iterative digit-by-digit integer square root, one result bit per cycle.
// dout_valid pulses DOUT_W+1 cycles after the din_valid cycle.
module sqrt
  import sqrt_sched_pkg::*;
#(
  parameter int DIN_W = 32,
  localparam int DOUT_W = calc_dout_w(DIN_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  input  logic [DIN_W-1:0]  din,
  output logic              dout_valid,
  output logic [DOUT_W-1:0] dout
);

  localparam int RAD_W = 2 * DOUT_W;
  localparam int CW    = $clog2(DOUT_W + 1);

  logic [RAD_W-1:0]  rad, rad_in;
  logic [DOUT_W-1:0] rem, root, rem_nx, root_nx;
  logic [DOUT_W+1:0] rem_sh, trial;
  logic [CW-1:0]     cnt;
  logic              run, take;
  logic              unused_trial_hi;

  // One restoring step: bring down two radicand bits and try root*4+1.
  // The remainder fits DOUT_W bits on every step that reuses it; only the
  // final, discarded remainder can be wider, so its top bits are dropped.
  always_comb begin
    rad_in          = RAD_W'(din);
    rem_sh          = {rem, rad[RAD_W-1 -: 2]};
    take            = rem_sh >= {root, 2'b01};
    trial           = rem_sh - {root, 2'b01};
    rem_nx          = take ? trial[DOUT_W-1:0] : rem_sh[DOUT_W-1:0];
    root_nx         = DOUT_W'({root, take});
    unused_trial_hi = |trial[DOUT_W+1:DOUT_W];
  end

  // Load on din_valid, iterate DOUT_W times, then pulse dout_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rad        <= '0;
      rem        <= '0;
      root       <= '0;
      cnt        <= '0;
      run        <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (din_valid) begin
        rad  <= rad_in;
        rem  <= '0;
        root <= '0;
        cnt  <= CW'(DOUT_W);
        run  <= 1'b1;
      end else if (run) begin
        rad  <= rad << 2;
        rem  <= rem_nx;
        root <= root_nx;
        cnt  <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          run        <= 1'b0;
          dout_valid <= 1'b1;
        end
      end
    end
  end

  assign dout = root;

endmodule

// File: rtl/sqrt_sched_arb.sv
// Request arbiter for sqrt_sched. With SQRT_SCHED_RR_EN defined it is a
// round-robin arbiter whose pointer moves only on adv; otherwise it is a
// fixed-priority (lowest index wins) arbiter with no state.
module sqrt_sched_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
`ifdef SQRT_SCHED_RR_EN
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
`endif
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx
);

`ifdef SQRT_SCHED_RR_EN
  logic [ID_W-1:0] ptr;
  logic            found;
  int              idx;

  // Search from ptr+1 upward, wrapping, first set request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = ID_W'(idx);
      end
    end
  end

  // Pointer remembers the last granted requester; starts at N_REQ-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      ptr <= ID_W'(N_REQ - 1);
    else if (adv) ptr <= gnt_idx;
  end
`else
  // Lowest index wins: scan downward so the last hit is the lowest.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        gnt     = '0;
        gnt[k]  = 1'b1;
        gnt_idx = ID_W'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/sqrt_sched.sv
// Shares one sqrt core among N_REQ requesters: arbitrate in IDLE, launch a
// single operation, wait for the result, hold it until the owner takes it.
// Optional round-robin arbitration: define SQRT_SCHED_RR_EN.
module sqrt_sched
  import sqrt_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DIN_W = 32,
  localparam int DOUT_W = calc_dout_w(DIN_W),
  localparam int ID_W   = calc_id_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*DIN_W-1:0] req_data,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [DOUT_W-1:0]      rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
);

  state_t            state, state_nxt;
  logic [N_REQ-1:0]  gnt, own_q, rsp_valid_q;
  logic [ID_W-1:0]   gnt_idx, id_q;
  logic [DIN_W-1:0]  opnd_q;
  logic [DOUT_W-1:0] res_q, core_dout;
  logic              core_dout_valid, din_valid, hs_req, rsp_hs, busy_q;

  sqrt_sched_arb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
`ifdef SQRT_SCHED_RR_EN
    .clk     (clk),
    .rst     (rst),
    .adv     (hs_req),
`endif
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  sqrt #(
    .DIN_W (DIN_W)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din        (opnd_q),
    .dout_valid (core_dout_valid),
    .dout       (core_dout)
  );

  // Only the requester that owns the held result can retire it.
  assign rsp_hs = |(rsp_ready & own_q);

  // State register; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, accept strobe and core launch.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    din_valid = 1'b0;
    hs_req    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst ? '0 : gnt;
        if (!rst && |req_valid) begin
          hs_req    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        din_valid = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:    if (core_dout_valid) state_nxt = RESP;
      RESP:    if (rsp_hs)          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/owner capture, result capture and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opnd_q      <= '0;
      id_q        <= '0;
      own_q       <= '0;
      res_q       <= '0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      busy_q <= (state_nxt != IDLE);
      if (hs_req) begin
        opnd_q <= req_data[int'(gnt_idx)*DIN_W +: DIN_W];
        id_q   <= gnt_idx;
        own_q  <= gnt;
      end
      if (state == WAIT && core_dout_valid) begin
        res_q       <= core_dout;
        rsp_valid_q <= own_q;
      end else if (state == RESP && rsp_hs) begin
        rsp_valid_q <= '0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = res_q;
  assign rsp_id    = id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sqrt_sched.sv
// Self-checking bench for sqrt_sched: directed latency/boundary/arbitration/
// backpressure/reset cases plus a random run, results checked by scoreboard.
module tb_sqrt_sched;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int OW = 16;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*DW-1:0] req_data;
  logic [OW-1:0] rsp_data;
  logic [IW-1:0] rsp_id;
  logic          busy;

  // Narrow, single-requester instance for odd radicand width.
  logic       req_valid9, req_ready9, rsp_valid9, rsp_ready9, busy9, rsp_id9;
  logic [8:0] req_data9;
  logic [4:0] rsp_data9;

  always #5 clk = ~clk;

  sqrt_sched #(.N_REQ(N), .DIN_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  sqrt_sched #(.N_REQ(1), .DIN_W(9)) dut9 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid9), .req_ready(req_ready9), .req_data(req_data9),
    .rsp_valid(rsp_valid9), .rsp_ready(rsp_ready9),
    .rsp_data(rsp_data9), .rsp_id(rsp_id9), .busy(busy9)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference floor(sqrt) by binary search on squares.
  function automatic longint isqrt(input longint x);
    longint lo, hi, mid;
    lo = 0;
    hi = 65536;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= x) lo = mid;
      else                hi = mid;
    end
    return lo;
  endfunction

  typedef struct { int id; longint val; } exp_t;
  exp_t   sb[$];
  int     gnt_log[$];
  longint hs_cyc[$];
  longint cyc = 0;
  int     n_rsp = 0;

  // Scoreboard: push on request handshake, pop and compare on response.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      sb.delete();
    end else begin
      if (rsp_valid != '0)
        chk("rsp_onehot", rsp_valid, 64'(1) << rsp_id);
      if ((rsp_valid & rsp_ready) != '0) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("rsp_data", rsp_data, e.val);
          chk("rsp_id", rsp_id, e.id);
          n_rsp++;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id  = i;
          e.val = isqrt(longint'(req_data[i*DW +: DW]));
          sb.push_back(e);
          gnt_log.push_back(i);
          hs_cyc.push_back(cyc);
        end
      end
    end
  end

  // Single request; returns cycles from handshake to first rsp_valid[i].
  task automatic do_req(input int i, input logic [31:0] d, output int lat);
    int n;
    req_data[i*DW +: DW] = d;
    req_valid[i] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[i] && n < 200);
    if (!req_ready[i]) chk("hs_timeout", req_ready[i], 1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    n = 1;
    while (n < 200) begin
      @(negedge clk);
      if (rsp_valid[i]) break;
      n++;
    end
    lat = n;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 300);
    chk(tag, busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_req9(input logic [8:0] d, input int exp);
    int n;
    req_data9  = d;
    req_valid9 = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready9 && n < 100);
    @(posedge clk); #1;
    req_valid9 = 1'b0;
    n = 1;
    while (n < 100) begin
      @(negedge clk);
      if (rsp_valid9) break;
      n++;
    end
    chk("d9_lat", n, 8);
    chk("d9_data", rsp_data9, exp);
    chk("d9_id", rsp_id9, 0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] k;
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return $urandom_range(0, 300);
      2:       return 32'hFFFF_FFFF - $urandom_range(0, 50);
      default: begin
        k = $urandom_range(0, 65535);
        return k * k - $urandom_range(0, 1);
      end
    endcase
  endfunction

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, seen, base, n;
    logic [N-1:0] fr;
    logic [31:0] bval [5];
    int          bexp [5];
    int          rr_exp [5];

    rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = '1;
    req_valid9 = 1'b0; req_data9 = '0; rsp_ready9 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req_valid = '1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_busy", busy, 0);
    req_valid = '0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Single request latency and value.
    do_req(2, 32'd1000000, lat);
    chk("t1_lat", lat, 19);
    chk("t1_data", rsp_data, 1000);
    chk("t1_id", rsp_id, 2);
    @(posedge clk); #1;

    // Boundary radicands.
    bval = '{32'd0, 32'd1, 32'd3, 32'd4, 32'hFFFF_FFFF};
    bexp = '{0, 1, 1, 2, 65535};
    for (int k = 0; k < 5; k++) begin
      do_req(k % N, bval[k], lat);
      chk("bnd_lat", lat, 19);
      chk("bnd_data", rsp_data, bexp[k]);
      @(posedge clk); #1;
    end

    // Odd width core.
    do_req9(9'd511, 22);
    do_req9(9'd0, 0);
    do_req9(9'd256, 16);

    // Arbitration order with everyone valid, from a fresh pointer.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    gnt_log.delete(); hs_cyc.delete();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'(i * 1000 + 7);
    req_valid = '1;
    n = 0;
    while (gnt_log.size() < 5 && n < 300) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle("t3_idle");
`ifdef SQRT_SCHED_RR_EN
    rr_exp = '{0, 1, 2, 3, 0};
`else
    rr_exp = '{0, 0, 0, 0, 0};
`endif
    chk("t3_count", gnt_log.size() >= 5, 1);
    for (int k = 0; k < 5 && k < gnt_log.size(); k++) chk("t3_order", gnt_log[k], rr_exp[k]);
    if (hs_cyc.size() >= 2) chk("t3_period", hs_cyc[1] - hs_cyc[0], 20);

    // Backpressure on requester 1 while requester 3 waits.
    rsp_ready[1] = 1'b0;
    do_req(1, 32'd4000000, lat);
    chk("t4_lat", lat, 19);
    req_data[3*DW +: DW] = 32'd81;
    req_valid[3] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("t4_rsp_valid", rsp_valid, 4'b0010);
      chk("t4_data", rsp_data, 2000);
      chk("t4_req_ready", req_ready, 0);
      chk("t4_busy", busy, 1);
    end
    @(posedge clk); #1;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    chk("t4_req_ready_R", req_ready, 0);
    @(negedge clk);
    chk("t4_next_grant", req_ready[3], 1);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    wait_idle("t4_idle");

    // Reset in the middle of an operation.
    req_data[0 +: DW] = 32'd999;
    req_valid[0] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[0] && n < 100);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_rsp_data", rsp_data, 0);
    chk("t5_rsp_id", rsp_id, 0);
    chk("t5_busy", busy, 0);
    chk("t5_req_ready", req_ready, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin @(negedge clk); if (rsp_valid != '0) seen++; end
    chk("t5_no_rsp", seen, 0);
    @(posedge clk); #1;
    do_req(0, 32'd144, lat);
    chk("t5_lat", lat, 19);
    chk("t5_data", rsp_data, 12);
    @(posedge clk); #1;

    // Random regression with response stalls.
    base = n_rsp;
    fr = '0;
    n = 0;
    while (n_rsp - base < 2000 && n < 90000) begin
      @(negedge clk);
      fr = req_valid & req_ready;
      n++;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (fr[i]) begin
          if ($urandom_range(0, 3) == 0) req_data[i*DW +: DW] = rnd_val();
          else                           req_valid[i] = 1'b0;
        end else if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req_valid[i] = 1'b1;
            req_data[i*DW +: DW] = rnd_val();
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
    end
    req_valid = '0;
    rsp_ready = '1;
    wait_idle("rand_idle");
    chk("rand_count", n_rsp - base >= 2000, 1);
    chk("sb_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sqrt_sched.md
# sqrt_sched

Shares one `sqrt` iterative core between `N_REQ` requesters. Each requester has a valid/ready request channel and a valid/ready response channel. The block arbitrates among pending requests, launches one operation at a time into the core, captures the result, and routes it back to the originating requester. It sits between the integer-math clients and the single `sqrt` instance, which it instantiates internally.

## Interface
- `N_REQ`, 4: number of requesters, ≥1.
- `DIN_W`, 32: radicand width, passed to `sqrt`.
- `DOUT_W`, `DIN_W/2 + DIN_W%2`: result width, derived, not overridden.
- `ID_W`, `max(1, $clog2(N_REQ))`: requester index width, derived.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester accept; at most one bit high.
- `req_data`  in  N_REQ*DIN_W  radicands; requester i at `[i*DIN_W +: DIN_W]`.
- `rsp_valid`  out  N_REQ  per-requester result valid; at most one bit high.
- `rsp_ready`  in  N_REQ  per-requester result accept.
- `rsp_data`  out  DOUT_W  `floor(sqrt(radicand))`, shared by all requesters.
- `rsp_id`  out  ID_W  index of the requester owning `rsp_data`.
- `busy`  out  1  high in every state except IDLE.

## Operation
FSM states are IDLE, ISSUE, WAIT and RESP.
- **IDLE**
  - The arbiter picks grant `g` among set `req_valid` bits.
  - `req_ready[g]=1`, combinational, only in IDLE.
  - On handshake: latch `req_data[g]` into the operand register and `g` into the id register, then go to ISSUE.
  - With no valid requests, stay in IDLE.
- **ISSUE**
  - Drive core `din_valid=1` for exactly this one cycle. The core is idle here by construction.
  - Go to WAIT.
- **WAIT**
  - `din_valid=0`.
  - On core `dout_valid`: capture `dout` into the result register, then go to RESP.
- **RESP**
  - `rsp_valid[id]=1`, `rsp_data` and `rsp_id` stable.
  - On `rsp_ready[id]`, go to IDLE. Other `rsp_ready` bits are ignored.
  - The core stays idle; no new request is accepted until the response is consumed.

Rules:
- Arbitration is evaluated only in IDLE. `req_valid` changes in other states have no effect.
- A requester that drops `req_valid` before handshake is not served.
- A requester may hold `req_valid` across its own response; it re-competes in IDLE.
- Width rules:
  - Odd `DIN_W` is handled by the core.
  - `rsp_data` is exactly `DOUT_W` bits, with no truncation.
  - `rsp_id` is zero-extended when `N_REQ=1`.

Reset:
- `rst` asserted at any time, including mid-calculation, forces IDLE immediately.
- Resets the core.
- Clears `req_ready`, `rsp_valid`, `rsp_data`, `rsp_id` and `busy` to 0, and clears the RR pointer to `N_REQ-1`, so requester 0 is first.
- In-flight operations are dropped without response.

## Timing
- Handshake in cycle H, ISSUE in H+1.
- Core `dout_valid` arrives at H+`DOUT_W`+2.
- `rsp_valid` is asserted from H+`DOUT_W`+3 until accepted. For `DIN_W=32` this is H+19.
- After the response handshake in cycle R, the next `req_ready` can assert in R+1.
- Throughput with `rsp_ready` tied high: one operation per `DOUT_W`+4 cycles.
- All outputs except `req_ready` are registered.

## Configuration
`SQRT_SCHED_RR_EN`:
- **Defined:** round-robin arbitration. Search starts at `last_grant+1` modulo `N_REQ`. The pointer updates only on a request handshake.
- **Undefined:** fixed priority, lowest index wins. The pointer logic is removed.

## Structure
- Package `sqrt_sched_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the `DOUT_W`/`ID_W` derivation functions.
- Sub-module `sqrt_sched_arb` contains:
  - a request vector in, a one-hot grant and encoded index out;
  - an advance strobe;
  - the RR pointer under the macro.
- `sqrt` is instantiated once with `DIN_W` passed through.

## Test plan
1. **Single request:** `N_REQ=4`, `DIN_W=32`; requester 2 sends 1000000 at H → `rsp_valid[2]` at H+19, `rsp_data`=1000, `rsp_id`=2.
2. **Boundary values:** 0→0, 1→1, 3→1, 4→2, 0xFFFFFFFF→65535. Also with `DIN_W=9`: 511→22.
3. **Round-robin (RR_EN):** all four requesters continuously valid, `rsp_ready` high → grant order 0,1,2,3,0. Without the macro → 0,0,0.
4. **Backpressure:** `rsp_ready[1]` held low 10 cycles → `rsp_valid[1]`/`rsp_data` stable, `req_ready` all 0, `busy`=1. Next grant in the cycle after acceptance.
5. **Mid-operation reset:** `rst` pulsed in WAIT → all outputs 0 asynchronously, no response for the dropped request. A new request of 144 returns 12 at normal latency.
6. **Random regression:** 2000 random radicands and `rsp_ready` stalls → each result equals `floor(sqrt)` and `rsp_id` matches the issuer.
